// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port 32-bit memory between a fetch port and a load/store port.
// Registered req/ack handshake per port, round-robin or fixed priority, with timeout and alignment errors.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int TIMEOUT    = 15,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // The counter is kept one bit wide when timeouts are disabled so it always has a legal width.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [1:0]        state_q, state_d;
    logic              lastGrantD_q, lastGrantD_d;
    logic              ownerD_q, ownerD_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              memReq_q, memReq_d;
    logic              busy_q, busy_d;
    logic              iAck_q, iAck_d, iErr_q, iErr_d;
    logic              dAck_q, dAck_d, dErr_q, dErr_d;
    logic [31:0]       iRdata_q, iRdata_d, dRdata_q, dRdata_d;
    logic              grantD;
    logic [ADDR_W-1:0] grantAddr;

    always_comb begin
        state_d      = state_q;
        lastGrantD_d = lastGrantD_q;
        ownerD_d     = ownerD_q;
        addr_d       = addr_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        memReq_d     = memReq_q;
        iAck_d       = 1'b0;
        iErr_d       = 1'b0;
        iRdata_d     = '0;
        dAck_d       = 1'b0;
        dErr_d       = 1'b0;
        dRdata_d     = '0;
        grantD       = 1'b0;
        grantAddr    = i_addr;

        case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    // On contention the port that did not win last time goes first, unless D has fixed priority.
                    grantD       = d_req && (!i_req || (FIXED_PRIO != 0) || !lastGrantD_q);
                    grantAddr    = grantD ? d_addr : i_addr;
                    ownerD_d     = grantD;
                    lastGrantD_d = grantD;
                    addr_d       = grantAddr;
                    we_d         = grantD && d_we;
                    be_d         = (grantD && d_we) ? d_be : 4'hF;
                    wdata_d      = grantD ? d_wdata : '0;
                    if (grantAddr[1:0] != 2'b00) begin
                        state_d = S_RESP;
                        iAck_d  = !grantD;
                        iErr_d  = !grantD;
                        dAck_d  = grantD;
                        dErr_d  = grantD;
                    end else begin
                        state_d  = S_BUSY;
                        memReq_d = 1'b1;
                        cnt_d    = '0;
                    end
                end
            end
            S_BUSY: begin
                if (mem_ready) begin
                    state_d  = S_RESP;
                    memReq_d = 1'b0;
                    iAck_d   = !ownerD_q;
                    dAck_d   = ownerD_q;
                    iRdata_d = ownerD_q ? '0 : mem_rdata;
                    dRdata_d = (ownerD_q && !we_q) ? mem_rdata : '0;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d  = S_RESP;
                    memReq_d = 1'b0;
                    iAck_d   = !ownerD_q;
                    iErr_d   = !ownerD_q;
                    dAck_d   = ownerD_q;
                    dErr_d   = ownerD_q;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lastGrantD_q <= 1'b1;
            ownerD_q     <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            memReq_q     <= 1'b0;
            busy_q       <= 1'b0;
            iAck_q       <= 1'b0;
            iErr_q       <= 1'b0;
            iRdata_q     <= '0;
            dAck_q       <= 1'b0;
            dErr_q       <= 1'b0;
            dRdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            lastGrantD_q <= lastGrantD_d;
            ownerD_q     <= ownerD_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            memReq_q     <= memReq_d;
            busy_q       <= busy_d;
            iAck_q       <= iAck_d;
            iErr_q       <= iErr_d;
            iRdata_q     <= iRdata_d;
            dAck_q       <= dAck_d;
            dErr_q       <= dErr_d;
            dRdata_q     <= dRdata_d;
        end
    end

    assign i_ack     = iAck_q;
    assign i_err     = iErr_q;
    assign i_rdata   = iRdata_q;
    assign d_ack     = dAck_q;
    assign d_err     = dErr_q;
    assign d_rdata   = dRdata_q;
    assign mem_req   = memReq_q;
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed and randomized accesses checked against a transaction-level model.
// A second instance with fixed data priority shares the inputs and is checked only during the contention run.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic        i_ack, i_err, d_ack, d_err, mem_req, mem_we, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        f_i_ack, f_i_err, f_d_ack, f_d_err, f_mem_req, f_mem_we, f_busy;
    logic [31:0] f_i_rdata, f_d_rdata, f_mem_addr, f_mem_wdata;
    logic [3:0]  f_mem_be;

    int compared   = 0;
    int mismatched = 0;
    bit modelLastD;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .TIMEOUT(15), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .TIMEOUT(15), .FIXED_PRIO(1)) dutFix (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(f_i_ack), .i_rdata(f_i_rdata), .i_err(f_i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(f_d_ack), .d_rdata(f_d_rdata), .d_err(f_d_err),
        .mem_req(f_mem_req), .mem_we(f_mem_we), .mem_be(f_mem_be), .mem_addr(f_mem_addr),
        .mem_wdata(f_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(f_busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulusI(input logic [31:0] addr);
        i_req  = 1'b1;
        i_addr = addr;
    endtask

    task automatic applyStimulusD(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                  input logic [31:0] wdata);
        d_req   = 1'b1;
        d_we    = we;
        d_be    = be;
        d_addr  = addr;
        d_wdata = wdata;
    endtask

    function automatic logic [31:0] randAddr(input bit misaligned);
        logic [31:0] a;
        a = $urandom();
        a[1:0] = misaligned ? 2'($urandom_range(1, 3)) : 2'b00;
        return a;
    endfunction

    // Serves one access from IDLE: the model picks the winner and predicts the memory command and response.
    task automatic serveOne(input string tag, input int waitCycles, input logic [31:0] rdVal,
                            input bit checkFixed, output bit wonD);
        bit          winD, fixD, mis, timedOut, eErr;
        logic [31:0] eAddr, eWdata, eRdata;
        logic        eWe;
        logic [3:0]  eBe;
        int          busyCycles;

        winD     = d_req && (!i_req || !modelLastD);
        fixD     = d_req;
        modelLastD = winD;
        wonD     = winD;
        eAddr    = winD ? d_addr : i_addr;
        eWe      = winD ? d_we : 1'b0;
        eBe      = (winD && d_we) ? d_be : 4'hF;
        eWdata   = d_wdata;
        mis      = (eAddr[1:0] != 2'b00);
        timedOut = 1'b0;
        busyCycles = 0;
        mem_ready  = 1'b0;

        @(posedge clk);
        @(negedge clk);
        if (mis) begin
            checkOutput({tag, "_noMemReq"}, {31'd0, mem_req}, 32'd0);
        end else begin
            checkOutput({tag, "_memWe"}, {31'd0, mem_we}, {31'd0, eWe});
            checkOutput({tag, "_memBe"}, {28'd0, mem_be}, {28'd0, eBe});
            if (eWe) checkOutput({tag, "_memWdata"}, mem_wdata, eWdata);
            while (mem_req === 1'b1 && busyCycles < 40) begin
                busyCycles++;
                checkOutput({tag, "_memAddr"}, mem_addr, eAddr);
                if (!i_req) i_addr = $urandom();
                if (!d_req) begin
                    d_addr  = $urandom();
                    d_wdata = $urandom();
                    d_we    = 1'($urandom_range(0, 1));
                    d_be    = 4'($urandom_range(0, 15));
                end
                mem_ready = (busyCycles == waitCycles + 1);
                mem_rdata = mem_ready ? rdVal : $urandom();
                @(posedge clk);
                @(negedge clk);
                mem_ready = 1'b0;
            end
            timedOut = (waitCycles >= 15);
            checkOutput({tag, "_reqCycles"}, busyCycles, timedOut ? 32'd15 : 32'(waitCycles + 1));
        end

        eErr   = mis || timedOut;
        eRdata = (eErr || eWe) ? 32'd0 : rdVal;
        checkOutput({tag, "_iAck"}, {31'd0, i_ack}, {31'd0, !winD});
        checkOutput({tag, "_dAck"}, {31'd0, d_ack}, {31'd0, winD});
        checkOutput({tag, "_iErr"}, {31'd0, i_err}, {31'd0, !winD && eErr});
        checkOutput({tag, "_dErr"}, {31'd0, d_err}, {31'd0, winD && eErr});
        checkOutput({tag, "_iRdata"}, i_rdata, winD ? 32'd0 : eRdata);
        checkOutput({tag, "_dRdata"}, d_rdata, winD ? eRdata : 32'd0);
        checkOutput({tag, "_busyResp"}, {31'd0, busy}, 32'd1);
        if (checkFixed) begin
            checkOutput({tag, "_fixDAck"}, {31'd0, f_d_ack}, {31'd0, fixD});
            checkOutput({tag, "_fixIAck"}, {31'd0, f_i_ack}, {31'd0, !fixD});
        end
        if (winD) d_req = 1'b0;
        else      i_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_ackDrop"}, {30'd0, i_ack, d_ack}, 32'd0);
        checkOutput({tag, "_busyIdle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit   wonD;
        logic [3:0] order;
        int   pick, waitC;

        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        modelLastD = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_memReq", {31'd0, mem_req}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
        checkOutput("rst_memBe", {28'd0, mem_be}, 32'd0);
        checkOutput("rst_memAddr", mem_addr, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulusI(32'h10);
        serveOne("fetch", 0, 32'h00500093, 1'b0, wonD);

        applyStimulusD(1'b1, 4'b0011, 32'h20, 32'hDEADBEEF);
        serveOne("store", 2, 32'h12345678, 1'b0, wonD);

        applyStimulusD(1'b0, 4'b0000, 32'h40, 32'h0);
        serveOne("load", 1, 32'hCAFEF00D, 1'b0, wonD);

        applyStimulusI(32'h100);
        serveOne("timeout", 100, 32'h11111111, 1'b0, wonD);

        applyStimulusD(1'b0, 4'hF, 32'h22, 32'h0);
        serveOne("misalign", 0, 32'h22222222, 1'b0, wonD);

        for (int n = 0; n < 30; n++) begin
            pick  = $urandom_range(1, 3);
            waitC = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
            if ((pick & 1) != 0 && !i_req)
                applyStimulusI(randAddr($urandom_range(0, 7) == 0));
            if ((pick & 2) != 0 && !d_req)
                applyStimulusD(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                               randAddr($urandom_range(0, 7) == 0), $urandom());
            serveOne("rand", waitC, $urandom(), 1'b0, wonD);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (2) @(negedge clk);

        applyStimulusI(32'h200);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rstBusy_memReq", {31'd0, mem_req}, 32'd0);
        checkOutput("rstBusy_busy", {31'd0, busy}, 32'd0);
        checkOutput("rstBusy_acks", {30'd0, i_ack, d_ack}, 32'd0);
        i_req = 1'b0;
        modelLastD = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        order = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            if (!i_req) applyStimulusI(randAddr(1'b0));
            if (!d_req) applyStimulusD(1'($urandom_range(0, 1)), 4'hF, randAddr(1'b0), $urandom());
            serveOne("contend", 0, $urandom(), 1'b1, wonD);
            order[n] = wonD;
        end
        checkOutput("contendOrder", {28'd0, order}, 32'b1010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
